// File: rtl/vga_pkg.sv
// Shared VGA timing package: 640x480@60 Hz constants, derived sync windows,
// coordinate type and a small range helper used by the timing generator and renderers.
package vga_pkg;

    // Coordinate width shared by x/y and every renderer comparison
    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixels
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing, in lines
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Derived sync windows (inclusive), sync is asserted low inside them
    localparam int unsigned VGA_HS_START = VGA_H_DISPLAY + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC - 1;
    localparam int unsigned VGA_VS_START = VGA_V_DISPLAY + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC - 1;

    // Default pixel divider: 100 MHz system clock down to 25 MHz pixel rate
    localparam int unsigned VGA_DIV = 4;

    // True when lo <= v <= hi
    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing bus published by vga_sync: pixel coordinate, blanking, sync and tick strobes.
// master = timing generator, slave = renderers / connector / game logic.
interface vga_sync_if;
    import vga_pkg::*;

    coord_t x;
    coord_t y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   p_tick;
    logic   frame_tick;

    modport master (
        output x, y, video_on, hsync, vsync, p_tick, frame_tick
    );

    modport slave (
        input x, y, video_on, hsync, vsync, p_tick, frame_tick
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable generator: div_cnt counts 0..DIV-1 and wraps; p_tick is high
// for the one system clock where the count sits at DIV-1 (constantly high for DIV=1).
module pixel_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(DIV - 1);

    cnt_t div_cnt_q;
    cnt_t div_cnt_d;

    // Next divider count: wrap at DIV-1
    always_comb begin
        div_cnt_d = div_cnt_q + cnt_t'(1);
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end
    end

    // Divider register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Pixel enable decoded straight from the register
    always_comb begin
        p_tick = (div_cnt_q == LAST);
    end

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel divider, horizontal/vertical counters published as the
// current pixel coordinate, registered active-low syncs, blanking decode and frame tick.
module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned DIV       = VGA_DIV,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP
) (
    input  logic          clk,
    input  logic          reset,
    vga_sync_if.master    vga
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACTIVE = coord_t'(H_DISPLAY);
    localparam coord_t V_ACTIVE = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic   p_tick;

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;

    pixel_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Next coordinate: advance one pixel per p_tick, wrapping line then frame
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + coord_t'(1);
                end
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    // Sync next-state decoded from the next coordinate so the registered syncs line up with x/y
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (p_tick) begin
            hsync_d = ~in_span(x_d, HS_START, HS_END);
            vsync_d = ~in_span(y_d, VS_START, VS_END);
        end
    end

    // Counter and sync registers, reset to the top-left idle state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // Published timing bus; blanking and frame tick are zero-latency decodes of the counters
    always_comb begin
        vga.x          = x_q;
        vga.y          = y_q;
        vga.hsync      = hsync_q;
        vga.vsync      = vsync_q;
        vga.p_tick     = p_tick;
        vga.video_on   = (x_q < H_ACTIVE) && (y_q < V_ACTIVE);
        vga.frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);
    end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: three instances (full 640x480 geometry at DIV=4, and a tiny
// 15x10 geometry at DIV=1 and DIV=3) checked every cycle against a model that derives
// all outputs from the number of clock edges since reset release, plus literal checks.
module tb_vga_sync;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    bit          done1    = 1'b0;

    // Edges since reset release, per reset domain
    int unsigned n0 = 0;
    int unsigned n1 = 0;

    vga_sync_if vif0 ();
    vga_sync_if vif1 ();
    vga_sync_if vif2 ();

    vga_sync #(
        .DIV (4)
    ) dut0 (
        .clk   (clk),
        .reset (rst0),
        .vga   (vif0)
    );

    vga_sync #(
        .DIV (1),
        .H_DISPLAY (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_DISPLAY (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .vga   (vif1)
    );

    vga_sync #(
        .DIV (3),
        .H_DISPLAY (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_DISPLAY (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut2 (
        .clk   (clk),
        .reset (rst1),
        .vga   (vif2)
    );

    always #5 clk = ~clk;

    // Edge counters since release
    always @(posedge clk or posedge rst0) begin
        if (rst0) n0 <= 0;
        else      n0 <= n0 + 1;
    end

    always @(posedge clk or posedge rst1) begin
        if (rst1) n1 <= 0;
        else      n1 <= n1 + 1;
    end

    // Expected {x, y, video_on, hsync, vsync, p_tick, frame_tick} after n edges
    function automatic logic [26:0] model(int unsigned n, int unsigned div,
                                          int unsigned hd, int unsigned hfp, int unsigned hs, int unsigned hbp,
                                          int unsigned vd, int unsigned vfp, int unsigned vs, int unsigned vbp);
        int unsigned ht, vt, p, x, y;
        logic pt, von, hsy, vsy, ft;
        ht  = hd + hfp + hs + hbp;
        vt  = vd + vfp + vs + vbp;
        p   = n / div;
        x   = p % ht;
        y   = (p / ht) % vt;
        pt  = ((n % div) == div - 1);
        von = (x < hd) && (y < vd);
        hsy = !((x >= hd + hfp) && (x < hd + hfp + hs));
        vsy = !((y >= vd + vfp) && (y < vd + vfp + vs));
        ft  = pt && (x == ht - 1) && (y == vt - 1);
        return {10'(x), 10'(y), von, hsy, vsy, pt, ft};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout: awaited condition not reached at t=%0t", name, $time);
    endtask

    // Wait (at negedges) for dut0 at a given x (and y if yv >= 0), optionally with p_tick high
    task automatic wait_dut0(input int xv, input int yv, input bit need_pt, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (vif0.x == 10'(xv) && (yv < 0 || vif0.y == 10'(yv)) && (!need_pt || vif0.p_tick))
                return;
        end
        timeout(name);
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        chk("dut0_outputs",
            {5'd0, vif0.x, vif0.y, vif0.video_on, vif0.hsync, vif0.vsync, vif0.p_tick, vif0.frame_tick},
            {5'd0, model(n0, 4, 640, 16, 96, 48, 480, 10, 2, 33)});
        chk("dut1_outputs",
            {5'd0, vif1.x, vif1.y, vif1.video_on, vif1.hsync, vif1.vsync, vif1.p_tick, vif1.frame_tick},
            {5'd0, model(n1, 1, 8, 2, 3, 2, 6, 1, 2, 1)});
        chk("dut2_outputs",
            {5'd0, vif2.x, vif2.y, vif2.video_on, vif2.hsync, vif2.vsync, vif2.p_tick, vif2.frame_tick},
            {5'd0, model(n1, 3, 8, 2, 3, 2, 6, 1, 2, 1)});
    end

    // Full-geometry instance: reset, cadence, hsync window, line wrap
    initial begin
        int unsigned pulses;
        logic [9:0]  xs;

        // Model pins: reset state and the last pixel tick of a full frame
        chk("model_reset_state", {5'd0, model(0, 4, 640, 16, 96, 48, 480, 10, 2, 33)},
            {5'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("model_frame_end", {5'd0, model(1679999, 4, 640, 16, 96, 48, 480, 10, 2, 33)},
            {5'd0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        chk("model_hsync_fall", {5'd0, model(656 * 4, 4, 640, 16, 96, 48, 480, 10, 2, 33)},
            {5'd0, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

        rst0 = 1'b1;
        #1;
        chk("rst_x", 32'(vif0.x), 32'd0);
        chk("rst_syncs", {30'd0, vif0.hsync, vif0.vsync}, 32'd3);
        chk("rst_ptick", 32'(vif0.p_tick), 32'd0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;

        // First tick and first pixel step after release
        repeat (3) @(posedge clk);
        #1;
        chk("ptick_after_3_edges", {21'd0, vif0.x, vif0.p_tick}, {21'd0, 10'd0, 1'b1});
        @(posedge clk);
        #1;
        chk("x1_on_4th_edge", {21'd0, vif0.x, vif0.p_tick}, {21'd0, 10'd1, 1'b0});

        // Pixel cadence over 400 clocks
        @(negedge clk);
        xs     = vif0.x;
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (vif0.p_tick) pulses++;
        end
        chk("ptick_count_400", pulses, 32'd100);
        chk("x_step_400", 32'(vif0.x), 32'(xs) + 32'd100);

        // Asynchronous reset mid-line at x=300
        wait_dut0(300, -1, 1'b0, 2000, "reach_x300");
        #($urandom_range(1, 4));
        rst0 = 1'b1;
        #1;
        chk("midline_rst_xy", {12'd0, vif0.x, vif0.y}, 32'd0);
        chk("midline_rst_flags", {29'd0, vif0.hsync, vif0.vsync, vif0.video_on}, 32'd7);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("x1_after_midline_rst", 32'(vif0.x), 32'd1);

        // Blanking and hsync window edges
        wait_dut0(639, 0, 1'b0, 4000, "reach_x639");
        chk("video_on_x639", 32'(vif0.video_on), 32'd1);
        wait_dut0(640, 0, 1'b0, 100, "reach_x640");
        chk("video_on_x640", 32'(vif0.video_on), 32'd0);
        wait_dut0(655, 0, 1'b0, 100, "reach_x655");
        chk("hsync_x655", 32'(vif0.hsync), 32'd1);
        wait_dut0(656, 0, 1'b0, 100, "reach_x656");
        chk("hsync_x656", 32'(vif0.hsync), 32'd0);
        wait_dut0(751, 0, 1'b0, 1000, "reach_x751");
        chk("hsync_x751", 32'(vif0.hsync), 32'd0);
        wait_dut0(752, 0, 1'b0, 100, "reach_x752");
        chk("hsync_x752", 32'(vif0.hsync), 32'd1);

        // Line wrap from x=799, y=10
        wait_dut0(799, 10, 1'b1, 40000, "reach_x799_y10");
        @(posedge clk);
        #1;
        chk("line_wrap_xy", {12'd0, vif0.x, vif0.y}, {12'd0, 10'd0, 10'd11});

        for (int i = 0; i < 20000 && !done1; i++) @(negedge clk);
        if (!done1) timeout("small_geometry_sequence");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Small-geometry instances: frame counting, frame wrap, DIV=1 behaviour, random resets
    initial begin
        int unsigned ft1, ft2;
        bit          found;

        rst1 = 1'b1;
        repeat (3) @(negedge clk);
        rst1 = 1'b0;

        // dut1 frame = 150 clks, dut2 frame = 450 clks
        ft1 = 0;
        ft2 = 0;
        for (int i = 1; i <= 900; i++) begin
            @(negedge clk);
            if (i <= 600 && vif1.frame_tick) ft1++;
            if (vif2.frame_tick) ft2++;
        end
        chk("dut1_frames_in_600", ft1, 32'd4);
        chk("dut2_frames_in_900", ft2, 32'd2);

        // Frame wrap on the DIV=1 instance
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (vif1.x == 10'd14 && vif1.y == 10'd9) found = 1'b1;
        end
        if (!found) timeout("dut1_reach_frame_end");
        chk("dut1_frame_tick_end", {30'd0, vif1.frame_tick, vif1.p_tick}, 32'd3);
        @(posedge clk);
        #1;
        chk("dut1_frame_wrap", {11'd0, vif1.x, vif1.y, vif1.frame_tick}, 32'd0);
        @(posedge clk);
        #1;
        chk("dut1_x_every_clk", {21'd0, vif1.x, vif1.p_tick}, {21'd0, 10'd1, 1'b1});

        // Random asynchronous resets at random points of the frame
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(20, 500)) @(negedge clk);
            #($urandom_range(1, 4));
            rst1 = 1'b1;
            #1;
            chk("rand_rst_dut2", {10'd0, vif2.x, vif2.y, vif2.hsync, vif2.vsync},
                {10'd0, 10'd0, 10'd0, 1'b1, 1'b1});
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst1 = 1'b0;
        end
        repeat (20) @(negedge clk);
        done1 = 1'b1;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the 640x480@60 Hz VGA output.
- Divides the 100 MHz system clock down to a pixel-rate enable.
- Runs the horizontal and vertical pixel counters and publishes them as the current pixel coordinate `x`/`y`.
- Those coordinates feed every glyph, paddle and ball renderer in the pong display path. Renderers return `display`, which is ORed into the colour mux gated by `video_on`.
- Generates active-low hsync/vsync for the connector and a once-per-frame tick that paces the game-state logic.

## Interface
- `DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz); legal range 1..16.
- `H_DISPLAY`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels (total 800).
- `V_DISPLAY`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines (total 525).
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `x`  out  10  current horizontal pixel count, 0..799.
- `y`  out  10  current vertical line count, 0..524.
- `video_on`  out  1  high when x<640 and y<480.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `p_tick`  out  1  one-clk pixel enable, every DIV clks.
- `frame_tick`  out  1  one-clk pulse on the last pixel tick of each frame.

## Operation
- **Divider.** `div_cnt` counts 0..DIV-1 and wraps.
  - `p_tick` = (div_cnt == DIV-1), combinational from the register.
  - With DIV=1, `p_tick` is constantly 1.
- **Counters.** `x` and `y` change only on an edge where `p_tick`=1.
  - On that edge, `x` increments.
  - At x=799: `x`→0 and `y` increments.
  - At x=799 and y=524: `x`→0 and `y`→0.
  - The counters never exceed 799/524. All arithmetic is 10-bit unsigned.
- **Sync outputs.** `hsync` and `vsync` are registers, loaded on the same `p_tick` edge from the *next* counter values, so they stay aligned with `x`/`y`.
  - `hsync` = 0 iff 656 ≤ x ≤ 751.
  - `vsync` = 0 iff 490 ≤ y ≤ 491.
- **`video_on`** is a combinational decode of the `x`/`y` registers.
- **`frame_tick`** = p_tick & (x==799) & (y==524). Exactly one clk-wide pulse per frame.
- **Reset values** (asserted asynchronously):
  - div_cnt=0, x=0, y=0, hsync=1, vsync=1.
  - Therefore video_on=1, p_tick=0 (for DIV>1), frame_tick=0.
- **Reset mid-operation.** All state returns to the reset values immediately. No partial line or frame completes. The first line after release is full length.

## Timing
- After reset release:
  - `p_tick` first goes high during the cycle after the DIV-1'th clk edge.
  - `x` becomes 1 on the DIV'th edge.
  - Each coordinate is held for exactly DIV clks.
- Line = 800×DIV clks (3200). Frame = 525 lines = 1,680,000 clks, about 59.5 Hz.
- `hsync` falls on the edge where `x` becomes 656 and rises on the edge where `x` becomes 752. It is low for 96 pixels.
- `vsync` falls on the edge where `y` becomes 490 and rises on the edge where `y` becomes 492. It is low for 2 lines.
- Renderers see `x`/`y`/`video_on` with zero latency. Their registered colour output lags by one clk, which is within the pixel period for DIV≥2.

## Structure
- Shared package `vga_pkg`:
  - the timing constants: H/V display, front porch, sync, back porch, totals;
  - the derived sync start/end values;
  - the coordinate width (10).
  - Renderers import the display extents from it.
- Sub-module `pixel_tick_gen` (`clk`, `reset`, parameter `DIV`, output `p_tick`) holds the divider.
- Counters and sync registers stay in `vga_sync`.

## Test plan
- **Reset values.** Assert `reset` mid-line at x=300.
  - Immediately: x=0, y=0, hsync=1, vsync=1, video_on=1.
  - After release with DIV=4: x=1 on the 4th edge.
- **Pixel cadence.** Over 400 clks, `p_tick` pulses exactly 100 times, each one clk wide. `x` steps 0→100.
- **Horizontal sync.**
  - `hsync` is 0 exactly for x 656..751 and 1 at x=655 and x=752.
  - `video_on` drops at x=640.
- **Line wrap.** At x=799, y=10, on `p_tick` → x=0, y=11.
- **Frame wrap.**
  - `vsync` is 0 only for y 490..491.
  - At x=799, y=524, on `p_tick`: `frame_tick`=1 for one clk, then x=0, y=0.
  - Exactly one `frame_tick` per 1,680,000 clks.
- **DIV=1 configuration.**
  - `p_tick` is constantly 1 and `x` increments every clk.
  - Frame length is 420,000 clks, with one `frame_tick`.
